// File: rtl/fetch_unit_if.sv
// Instruction-memory bus plus the IF/ID register outputs toward decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  // Fetch unit side: drives the memory request and the IF/ID outputs.
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata
  );

  // Memory/decode side.
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/REQ/HOLD FSM, one-entry skid buffer for an
// instruction that arrives while decode is stalled, and the IF/ID register.
// The PC register itself lives outside; this block computes pc_next.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_in,
  output logic [31:0]  pc_next,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  assign bus.imem_addr = pc_in;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

  // Next-state, next-PC and IF/ID/skid update selection.
  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    pc_next      = pc_in;
    bus.imem_req = 1'b0;

    if (rst) begin
      // Register clearing happens in the sequential block; only the
      // combinational outputs need forcing here.
      pc_next = RESET_PC;
    end else if (redirect) begin
      // Redirect beats stall and ack: any returning word is dropped and the
      // skid entry is thrown away. imem_req still reflects the state.
      bus.imem_req = (state_q == REQ);
      pc_next      = redirect_pc & 32'hFFFF_FFFC;
      if_valid_d   = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      state_d      = REQ;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          bus.imem_req = 1'b1;
          if (bus.imem_ack) begin
            pc_next = pc_in + PC_STEP;
            if (!stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_in;
              if_instr_d = bus.imem_rdata;
            end else begin
              skid_pc_d    = pc_in;
              skid_instr_d = bus.imem_rdata;
              state_d      = HOLD;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_instr_d = skid_instr_q;
            state_d    = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, IF/ID and skid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench owns the PC register.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, pc_next, pc_q;
  int          nchecks = 0;
  int          nerrors = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_q), .pc_next(pc_next), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_q <= pc_next;

  // Apply inputs at the falling edge, settle 1 time unit.
  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic ack,
                       input logic [31:0] rdata);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    bus.imem_ack = ack; bus.imem_rdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 32'h55, 1, 32'hDEAD);
    nchecks++; if (pc_next !== 32'h0) begin nerrors++; $display("FAIL rst_pc_next got %h exp %h", pc_next, 32'h0); end
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL rst_req got %b exp 0", bus.imem_req); end
    tick();
    drive(1, 0, 0, 0, 1, 32'hBEEF);
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL rst_valid got %b exp 0", bus.if_valid); end
    nchecks++; if (bus.if_pc !== 32'h0) begin nerrors++; $display("FAIL rst_if_pc got %h exp 0", bus.if_pc); end
    nchecks++; if (bus.if_instr !== 32'h0) begin nerrors++; $display("FAIL rst_if_instr got %h exp 0", bus.if_instr); end
    drive(0, 0, 0, 0, 0, 0);
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL idle_req got %b exp 0", bus.imem_req); end
    nchecks++; if (pc_next !== 32'h0) begin nerrors++; $display("FAIL idle_pc_next got %h exp 0", pc_next); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    nchecks++; if (bus.imem_req !== 1'b1) begin nerrors++; $display("FAIL first_req got %b exp 1", bus.imem_req); end
    nchecks++; if (bus.imem_addr !== 32'h0) begin nerrors++; $display("FAIL first_addr got %h exp 0", bus.imem_addr); end
  endtask

  // Back-to-back acks: one instruction per cycle, one-cycle latency.
  task automatic test_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, words[i]);
      nchecks++; if (pc_next !== 32'(4*i+4)) begin nerrors++; $display("FAIL b2b_pc_next[%0d] got %h exp %h", i, pc_next, 32'(4*i+4)); end
      tick();
      nchecks++; if (bus.if_valid !== 1'b1) begin nerrors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, bus.if_valid); end
      nchecks++; if (bus.if_pc !== 32'(4*i)) begin nerrors++; $display("FAIL b2b_pc[%0d] got %h exp %h", i, bus.if_pc, 32'(4*i)); end
      nchecks++; if (bus.if_instr !== words[i]) begin nerrors++; $display("FAIL b2b_instr[%0d] got %h exp %h", i, bus.if_instr, words[i]); end
    end
  endtask

  task automatic test_wait();
    drive(0, 0, 1, 32'h10, 0, 0);
    nchecks++; if (pc_next !== 32'h10) begin nerrors++; $display("FAIL wait_redir got %h exp 10", pc_next); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      nchecks++; if (bus.imem_req !== 1'b1) begin nerrors++; $display("FAIL wait_req[%0d] got %b exp 1", i, bus.imem_req); end
      nchecks++; if (pc_next !== 32'h10) begin nerrors++; $display("FAIL wait_pc_next[%0d] got %h exp 10", i, pc_next); end
      tick();
      nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL wait_valid[%0d] got %b exp 0", i, bus.if_valid); end
    end
    drive(0, 0, 0, 0, 1, 32'hAA);
    nchecks++; if (pc_next !== 32'h14) begin nerrors++; $display("FAIL wait_ack_pc_next got %h exp 14", pc_next); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b1) begin nerrors++; $display("FAIL wait_done_valid got %b exp 1", bus.if_valid); end
    nchecks++; if (bus.if_pc !== 32'h10) begin nerrors++; $display("FAIL wait_done_pc got %h exp 10", bus.if_pc); end
    nchecks++; if (bus.if_instr !== 32'hAA) begin nerrors++; $display("FAIL wait_done_instr got %h exp aa", bus.if_instr); end
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 32'h20, 0, 0);
    tick();
    drive(0, 1, 0, 0, 1, 32'hBB);
    nchecks++; if (pc_next !== 32'h24) begin nerrors++; $display("FAIL stall_pc_next got %h exp 24", pc_next); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL stall_valid got %b exp 0", bus.if_valid); end
    nchecks++; if (bus.if_instr !== 32'hAA) begin nerrors++; $display("FAIL stall_held_instr got %h exp aa", bus.if_instr); end
    drive(0, 1, 0, 0, 1, 32'hCC);
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL hold_req got %b exp 0", bus.imem_req); end
    nchecks++; if (pc_next !== 32'h24) begin nerrors++; $display("FAIL hold_pc_next got %h exp 24", pc_next); end
    tick();
    nchecks++; if (bus.if_pc !== 32'h10) begin nerrors++; $display("FAIL hold_pc got %h exp 10", bus.if_pc); end
    drive(0, 0, 0, 0, 0, 0);
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL release_req got %b exp 0", bus.imem_req); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b1) begin nerrors++; $display("FAIL release_valid got %b exp 1", bus.if_valid); end
    nchecks++; if (bus.if_pc !== 32'h20) begin nerrors++; $display("FAIL release_pc got %h exp 20", bus.if_pc); end
    nchecks++; if (bus.if_instr !== 32'hBB) begin nerrors++; $display("FAIL release_instr got %h exp bb", bus.if_instr); end
    drive(0, 0, 0, 0, 1, 32'hDD);
    nchecks++; if (bus.imem_addr !== 32'h24) begin nerrors++; $display("FAIL resume_addr got %h exp 24", bus.imem_addr); end
    tick();
    nchecks++; if (bus.if_pc !== 32'h24) begin nerrors++; $display("FAIL resume_pc got %h exp 24", bus.if_pc); end
  endtask

  task automatic test_redirect();
    drive(0, 1, 1, 32'h103, 1, 32'hEE);
    nchecks++; if (pc_next !== 32'h100) begin nerrors++; $display("FAIL redir_pc_next got %h exp 100", pc_next); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL redir_valid got %b exp 0", bus.if_valid); end
    nchecks++; if (bus.if_instr !== 32'hDD) begin nerrors++; $display("FAIL redir_drop got %h exp dd", bus.if_instr); end
    drive(0, 0, 0, 0, 0, 0);
    nchecks++; if (bus.imem_addr !== 32'h100) begin nerrors++; $display("FAIL redir_addr got %h exp 100", bus.imem_addr); end
    nchecks++; if (bus.imem_req !== 1'b1) begin nerrors++; $display("FAIL redir_req got %b exp 1", bus.imem_req); end
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    nchecks++; if (pc_next !== 32'hFFFF_FFFC) begin nerrors++; $display("FAIL wrap_redir got %h exp fffffffc", pc_next); end
    tick();
    drive(0, 0, 0, 0, 1, 32'h77);
    nchecks++; if (pc_next !== 32'h0) begin nerrors++; $display("FAIL wrap_pc_next got %h exp 0", pc_next); end
    tick();
    nchecks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin nerrors++; $display("FAIL wrap_if_pc got %h exp fffffffc", bus.if_pc); end
  endtask

  task automatic test_reset_hold();
    drive(0, 1, 0, 0, 1, 32'h99);
    tick();
    drive(1, 0, 0, 0, 1, 32'h88);
    nchecks++; if (pc_next !== 32'h0) begin nerrors++; $display("FAIL rhold_pc_next got %h exp 0", pc_next); end
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL rhold_req got %b exp 0", bus.imem_req); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL rhold_valid got %b exp 0", bus.if_valid); end
    nchecks++; if (bus.if_instr !== 32'h0) begin nerrors++; $display("FAIL rhold_instr got %h exp 0", bus.if_instr); end
    drive(0, 0, 0, 0, 1, 32'h66);
    nchecks++; if (bus.imem_req !== 1'b0) begin nerrors++; $display("FAIL rhold_idle_req got %b exp 0", bus.imem_req); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL rhold_idle_valid got %b exp 0", bus.if_valid); end
    drive(0, 0, 0, 0, 0, 0);
    nchecks++; if (bus.imem_req !== 1'b1) begin nerrors++; $display("FAIL rhold_req2 got %b exp 1", bus.imem_req); end
    tick();
    nchecks++; if (bus.if_valid !== 1'b0) begin nerrors++; $display("FAIL rhold_skid_gone got %b exp 0", bus.if_valid); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_hold();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, SHALL be the fetch address after reset.
REQ-002 Parameter PC_STEP, 4, SHALL be the sequential PC increment in bytes.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pc_in  in  32  current PC, from PC register output.
REQ-006 pc_next  out  32  next PC, combinational, drives PC register input (loaded every posedge clk).
REQ-007 stall  in  1  decode cannot accept; IF/ID register SHALL hold.
REQ-008 redirect  in  1  taken branch/jump from execute; flush and retarget.
REQ-009 redirect_pc  in  32  target address for redirect.
REQ-010 imem_req  out  1  instruction memory read request.
REQ-011 imem_addr  out  32  read address; SHALL equal pc_in.
REQ-012 imem_ack  in  1  imem_rdata valid this cycle; ignored unless imem_req=1.
REQ-013 imem_rdata  in  32  fetched instruction word.
REQ-014 if_valid, if_pc, if_instr  out  1/32/32  registered IF/ID outputs to decode.

Function
REQ-015 The FSM SHALL have states IDLE, REQ and HOLD, all registered.
REQ-016 IDLE: imem_req=0, pc_next=pc_in; next state REQ unconditionally.
REQ-017 REQ: imem_req=1; with no imem_ack: pc_next=pc_in, state stays REQ.
REQ-018 REQ, imem_ack=1, stall=0: if_valid<=1, if_pc<=pc_in, if_instr<=imem_rdata, pc_next=pc_in+PC_STEP, state stays REQ.
REQ-019 REQ, imem_ack=1, stall=1: skid buffer<={pc_in,imem_rdata}, pc_next=pc_in+PC_STEP, IF/ID held, next state HOLD.
REQ-020 HOLD: imem_req=0, pc_next=pc_in; while stall=1 stay HOLD with IF/ID held; when stall=0, IF/ID<=skid buffer with if_valid<=1, next state REQ.
REQ-021 REQ without a captured instruction and stall=0: if_valid<=0 (bubble), if_pc/if_instr unchanged.
REQ-022 Any state with stall=1 and no redirect: if_valid, if_pc and if_instr SHALL hold.
REQ-023 redirect=1 in any state SHALL take priority over stall and imem_ack: pc_next={redirect_pc[31:2],2'b00}, if_valid<=0, skid buffer discarded, next state REQ.
REQ-024 An imem_ack coinciding with redirect SHALL be dropped and never reach IF/ID.
REQ-025 Addition pc_in+PC_STEP SHALL be modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-026 Throughput SHALL be one instruction per cycle when imem_ack=1 every cycle and stall=0; latency imem_ack to if_valid SHALL be one posedge clk.

Reset
REQ-027 While rst=1: pc_next=RESET_PC, imem_req=0, regardless of other inputs.
REQ-028 At posedge clk with rst=1: state<=IDLE, if_valid<=0, if_pc<=0, if_instr<=0, skid buffer cleared.
REQ-029 rst asserted mid-fetch (REQ or HOLD) SHALL discard any pending instruction; a concurrent imem_ack SHALL be ignored.
REQ-030 First imem_req after rst falls SHALL occur in the second cycle, with imem_addr=RESET_PC.

Verification
REQ-031 Reset then imem_ack=1 every cycle, rdata=0x11,0x22,0x33 -> if_pc 0,4,8 with if_instr 0x11,0x22,0x33 on consecutive cycles, if_valid=1.
REQ-032 imem_ack delayed 3 cycles at pc_in=0x10 -> imem_req stays 1, pc_next=0x10 for 3 cycles, if_valid=0, then if_pc=0x10.
REQ-033 stall=1 on the ack cycle for pc_in=0x20 -> state HOLD, imem_req=0, IF/ID unchanged; stall=0 two cycles later -> if_pc=0x20 next cycle, fetch resumes at 0x24.
REQ-034 redirect=1, redirect_pc=0x103 with simultaneous imem_ack and stall=1 -> pc_next=0x100, if_valid=0 next cycle, next fetch address 0x100.
REQ-035 pc_in=0xFFFF_FFFC with ack, stall=0 -> pc_next=0x0000_0000.
REQ-036 rst=1 asserted in HOLD with ack=1 -> next cycle if_valid=0, pc_next=RESET_PC, state IDLE.
